// File: rtl/mult_share_arbiter.sv
// Two-requester front end for one shared sequential multiplier.
// Round-robin on ties, with a timeout guard on the multiplier handshake.
module mult_share_arbiter #(
  parameter int W       = 8,
  parameter int TIMEOUT = 63
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req0,
  input  logic           req1,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           valid0,
  output logic           valid1,
  output logic [2*W-1:0] product,
  output logic           err,
  output logic           busy,
  output logic           m_start,
  output logic [W-1:0]   m_mcand,
  output logic [W-1:0]   m_mplier,
  input  logic           m_done,
  input  logic [2*W-1:0] m_product
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             valid0_q, valid0_d;
  logic             valid1_q, valid1_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             m_start_q, m_start_d;
  logic [2*W-1:0]   product_q, product_d;
  logic [W-1:0]     mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic             pick1;

  // Requester 1 wins alone, or on a tie when requester 0 was served last.
  assign pick1   = req1 & (~req0 | ~last_q);
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    valid0_d  = 1'b0;
    valid1_d  = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    m_start_d = 1'b0;
    product_d = product_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d   = START;
          owner_d   = pick1;
          mcand_d   = pick1 ? a1 : a0;
          mplier_d  = pick1 ? b1 : b0;
          gnt0_d    = ~pick1;
          gnt1_d    = pick1;
          m_start_d = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
        end
      end
      START: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (m_done) begin
          state_d   = DONE;
          product_d = m_product;
          valid0_d  = ~owner_q;
          valid1_d  = owner_q;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          state_d   = DONE;
          product_d = '0;
          err_d     = 1'b1;
          valid0_d  = ~owner_q;
          valid1_d  = owner_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      valid0_q  <= 1'b0;
      valid1_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      m_start_q <= 1'b0;
      product_q <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      valid0_q  <= valid0_d;
      valid1_q  <= valid1_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      m_start_q <= m_start_d;
      product_q <= product_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign valid0   = valid0_q;
  assign valid1   = valid1_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign m_start  = m_start_q;
  assign product  = product_q;
  assign m_mcand  = mcand_q;
  assign m_mplier = mplier_q;

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 8, the operand width in bits; the product width is 2*W.
REQ-002 The block SHALL have parameter TIMEOUT, default 63, the maximum number of WAIT cycles allowed for m_done.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clock  in  1  rising-edge clock for all state
- reset  in  1  synchronous active-high reset
- req0 / req1  in  1  request from requester 0 / 1
- a0, b0 / a1, b1  in  W  signed multiplicand / multiplier for requester 0 / 1
- gnt0 / gnt1  out  1  one-cycle pulse: operands captured
- valid0 / valid1  out  1  one-cycle pulse: result ready for requester 0 / 1
- product  out  2W  shared result bus, meaningful only while valid0 or valid1 is high
- err  out  1  high with valid: the result timed out
- busy  out  1  high in any state other than IDLE
- m_start  out  1  start pulse to the shared Booth multiplier
- m_mcand, m_mplier  out  W  registered operands to the multiplier
- m_done  in  1  multiplier completion
- m_product  in  2W  multiplier result

Function
REQ-004 The block SHALL implement the states IDLE, START, WAIT and DONE, in that order, with DONE returning to IDLE.
REQ-005 IDLE SHALL sample req0 and req1 only in IDLE.
- If either is high, the block registers that requester's a/b into m_mcand/m_mplier, records the owner, and moves to START.
- If neither is high, it stays in IDLE.
REQ-006 Arbitration SHALL be round-robin when both requests are high.
- A last_owner bit selects the requester not served most recently.
- If only one request is high, that requester wins regardless of last_owner.
REQ-007 START SHALL last exactly one cycle: m_start=1, the owner's gnt=1, the timeout counter cleared, then the block moves to WAIT.
REQ-008 Requesters SHALL hold req and operands stable until they see gnt.
- A req still high in the cycle after gnt is treated as a new request in the next IDLE.
REQ-009 WAIT SHALL increment the timeout counter each cycle.
- If m_done=1, the block captures m_product into product, sets err=0 and moves to DONE.
- Else, if the counter equals TIMEOUT, the block sets product=0, err=1 and moves to DONE.
REQ-010 If m_done and the timeout occur in the same cycle, m_done SHALL win (err=0).
REQ-011 m_done SHALL be ignored in IDLE, START and DONE.
REQ-012 DONE SHALL last exactly one cycle: the owner's valid=1, product/err held, last_owner updated to the owner, then the block moves to IDLE.
REQ-013 Latency SHALL be as follows:
- req seen in IDLE at cycle 0 gives gnt/m_start in cycle 1.
- WAIT begins in cycle 2.
- m_done in cycle k gives valid in cycle k+1.
- The next IDLE sample is at cycle k+2.
REQ-014 gnt0/gnt1 SHALL never be high together, and valid0/valid1 SHALL never be high together.
REQ-015 m_mcand/m_mplier SHALL remain stable from START through DONE.
REQ-016 product SHALL retain its last value outside DONE; err SHALL be 0 outside DONE.
REQ-017 The timeout counter SHALL be wide enough to hold TIMEOUT without wrap-around.

Reset
REQ-018 Reset SHALL force state=IDLE and last_owner=1, so that requester 0 wins the first tie.
REQ-019 Reset SHALL clear every output to 0: gnt0, gnt1, valid0, valid1, err, busy, m_start, product, m_mcand, m_mplier.
REQ-020 Reset SHALL clear the timeout counter.
REQ-021 Reset asserted mid-operation SHALL abandon the transaction with no valid pulse.
- A later m_done is ignored until a new START.

Verification
REQ-022 Single request: after reset, req0=1, a0=3, b0=-5; multiplier model returns m_done 8 cycles after m_start -> gnt0 in cycle 1, m_start in cycle 1, valid0 with product=-15 (16'hFFF1), err=0, valid1 never asserted.
REQ-023 Tie after reset: req0=req1=1 held -> first grant to requester 0, second grant to requester 1, third grant to requester 0; no gnt0/gnt1 overlap.
REQ-024 Timeout: m_done held 0 after m_start -> valid pulse after exactly 63 WAIT cycles with err=1, product=0; the block then returns to IDLE and serves the next request normally.
REQ-025 Simultaneous events: m_done=1 in the same cycle the counter reaches TIMEOUT, m_product=16'h0042 -> err=0, product=16'h0042.
REQ-026 Reset mid-WAIT: assert reset for 1 cycle during WAIT, then deliver m_done -> no valid pulse; all outputs read 0; busy=0.
REQ-027 Stray done: m_done=1 while in IDLE -> no state change, no valid pulse.
